// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: op encodings and
// the width helper for the return-address stack occupancy count.
package pc_pkg;

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BRR  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_RETI = 3'd5;

  // Occupancy counter must represent 0..entries inclusive.
  function automatic int unsigned depth_width(input int unsigned entries);
    return $clog2(entries + 1);
  endfunction

  localparam int unsigned DEF_STACK_DEPTH = 8;
  localparam int unsigned DEF_DEPTH_W     = depth_width(DEF_STACK_DEPTH);

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Hardware return-address stack: a LIFO of STACK_DEPTH entries.
// Push on full and pop on empty are ignored here; the caller flags
// them as errors. Contents are not reset, only the occupancy count.
module ras_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_W     = depth_width(STACK_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic [DEPTH_W-1:0] depth,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0]  mem_q [STACK_DEPTH];
  logic [ADDR_W-1:0]  mem_d [STACK_DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] depth_d;
  logic [IDX_W-1:0]   wr_idx_s;
  logic [IDX_W-1:0]   rd_idx_s;

  // Next free slot is the low bits of depth; the top entry sits one below it.
  // At a power-of-two full depth the wrapped write index is never used.
  assign wr_idx_s = depth_q[IDX_W-1:0];
  assign rd_idx_s = wr_idx_s - IDX_W'(1'b1);

  assign top_data = mem_q[rd_idx_s];
  assign depth    = depth_q;
  assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty    = (depth_q == {DEPTH_W{1'b0}});

  // Next-state for contents and count; push and pop never arrive together.
  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push && !full) begin
      mem_d[wr_idx_s] = push_data;
      depth_d         = depth_q + DEPTH_W'(1'b1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DEPTH_W'(1'b1);
    end else begin
      depth_d = depth_q;
    end
  end

  // Occupancy count, cleared on reset so the stack is abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= {DEPTH_W{1'b0}};
    end else begin
      depth_q <= depth_d;
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: sequential step, jump, relative branch,
// call/return through ras_stack, and single-level interrupt entry/exit.
// Every output comes straight from a flop; an op seen at one edge is
// visible on pc after that edge.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              ADDR_W      = 16,
  parameter int              STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(16'h0004)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic [2:0]                       op,
  input  logic [ADDR_W-1:0]                target,
  input  logic [ADDR_W-1:0]                offset,
  input  logic                             irq,
  output logic [ADDR_W-1:0]                pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             stk_full,
  output logic                             stk_empty,
  output logic                             stk_err,
  output logic                             in_isr,
  output logic                             irq_ack
);

  localparam int DEPTH_W = depth_width(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(1'b1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              in_isr_q, in_isr_d;
  logic              stk_err_q, stk_err_d;
  logic              irq_ack_q, irq_ack_d;
  logic              push_s, pop_s;
  logic [ADDR_W-1:0] push_data_s;
  logic [ADDR_W-1:0] top_data_s;
  logic              full_s, empty_s;

  ras_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .DEPTH_W     (DEPTH_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (push_data_s),
    .top_data  (top_data_s),
    .depth     (depth),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign pc        = pc_q;
  assign in_isr    = in_isr_q;
  assign stk_err   = stk_err_q;
  assign irq_ack   = irq_ack_q;
  assign stk_full  = full_s;
  assign stk_empty = empty_s;

  // Priority: stall freezes everything, then interrupt entry, then the op.
  always_comb begin
    pc_d        = pc_q;
    in_isr_d    = in_isr_q;
    stk_err_d   = stk_err_q;
    irq_ack_d   = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    push_data_s = pc_q;
    if (stall) begin
      pc_d = pc_q;
    end else if (irq && !in_isr_q && !full_s) begin
      // Save the instruction that has not executed yet; drop this cycle's op.
      push_s      = 1'b1;
      push_data_s = pc_q;
      pc_d        = IRQ_VEC;
      in_isr_d    = 1'b1;
      irq_ack_d   = 1'b1;
    end else begin
      case (op)
        OP_JMP: begin
          pc_d = target;
        end
        OP_BRR: begin
          pc_d = pc_q + offset;
        end
        OP_CALL: begin
          pc_d = target;
          if (!full_s) begin
            push_s      = 1'b1;
            push_data_s = pc_q + PC_INC;
          end else begin
            stk_err_d = 1'b1;
          end
        end
        OP_RET, OP_RETI: begin
          if (!empty_s) begin
            pop_s = 1'b1;
            pc_d  = top_data_s;
          end else begin
            pc_d      = pc_q + PC_INC;
            stk_err_d = 1'b1;
          end
          if (op == OP_RETI) begin
            in_isr_d = 1'b0;
          end else begin
            in_isr_d = in_isr_q;
          end
        end
        default: begin
          pc_d = pc_q + PC_INC;
        end
      endcase
    end
  end

  // Architectural state; reset returns to the vector with a clean ISR state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_VEC;
      in_isr_q  <= 1'b0;
      stk_err_q <= 1'b0;
      irq_ack_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      in_isr_q  <= in_isr_d;
      stk_err_q <= stk_err_d;
      irq_ack_q <= irq_ack_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: each task queues rows of stimulus with
// hand-derived expected outputs, pushes the expectation as the row is
// driven and pops/compares it once the clock edge has taken effect.
module tb_pc_unit;

  localparam logic [2:0] SEQ  = 3'd0;
  localparam logic [2:0] JMP  = 3'd1;
  localparam logic [2:0] BRR  = 3'd2;
  localparam logic [2:0] CALL = 3'd3;
  localparam logic [2:0] RET  = 3'd4;
  localparam logic [2:0] RETI = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] target = 16'h0000;
  logic [15:0] offset = 16'h0000;
  logic        irq = 1'b0;
  logic [15:0] pc;
  logic [3:0]  depth;
  logic        stk_full, stk_empty, stk_err, in_isr, irq_ack;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  depth;
    logic        full;
    logic        empty;
    logic        err;
    logic        isr;
    logic        ack;
  } obs_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] tgt;
    logic [15:0] off;
    logic        irq;
    logic        stall;
    obs_t        exp;
  } row_t;

  obs_t sb[$];
  row_t rows[$];
  int   cmp_n = 0;
  int   bad_n = 0;

  pc_unit #(
    .ADDR_W      (16),
    .STACK_DEPTH (8),
    .RESET_VEC   (16'h0000),
    .IRQ_VEC     (16'h0004)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .op        (op),
    .target    (target),
    .offset    (offset),
    .irq       (irq),
    .pc        (pc),
    .depth     (depth),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_err   (stk_err),
    .in_isr    (in_isr),
    .irq_ack   (irq_ack)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [15:0] p, input logic [3:0] d,
                              input logic e, input logic i, input logic a);
    obs_t o;
    o.pc    = p;
    o.depth = d;
    o.full  = (d == 4'd8);
    o.empty = (d == 4'd0);
    o.err   = e;
    o.isr   = i;
    o.ack   = a;
    return o;
  endfunction

  function automatic row_t rw(input logic [2:0] o, input logic [15:0] t,
                              input logic [15:0] f, input logic q,
                              input logic s, input obs_t x);
    row_t r;
    r.op = o; r.tgt = t; r.off = f; r.irq = q; r.stall = s; r.exp = x;
    return r;
  endfunction

  function automatic obs_t sample();
    return {pc, depth, stk_full, stk_empty, stk_err, in_isr, irq_ack};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pc=%h depth=%0d full=%b empty=%b err=%b isr=%b ack=%b",
                     o.pc, o.depth, o.full, o.empty, o.err, o.isr, o.ack);
  endfunction

  task automatic drive(input row_t r);
    op = r.op; target = r.tgt; offset = r.off; irq = r.irq; stall = r.stall;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    op = SEQ; irq = 1'b0; stall = 1'b0; target = 16'h0000; offset = 16'h0000;
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, want;
    op = JMP; target = 16'h1234; irq = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    sb.push_back(mk(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0));
    got = sample(); want = sb.pop_front(); cmp_n++;
    if (got !== want) begin
      bad_n++; $display("FAIL reset: got %s want %s", fmt(got), fmt(want));
    end
    apply_reset();
  endtask

  task automatic test_seq();
    obs_t got, want;
    rows.push_back(rw(SEQ, 16'h0, 16'h0, 1'b0, 1'b0, mk(16'h0001, 4'd0, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(SEQ, 16'h0, 16'h0, 1'b0, 1'b0, mk(16'h0002, 4'd0, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(SEQ, 16'h0, 16'h0, 1'b0, 1'b0, mk(16'h0003, 4'd0, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(JMP, 16'hFFFF, 16'h0, 1'b0, 1'b0, mk(16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(7,   16'h0, 16'h0, 1'b0, 1'b0, mk(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(6,   16'h0, 16'h0, 1'b0, 1'b0, mk(16'h0001, 4'd0, 1'b0, 1'b0, 1'b0)));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i].exp);
      tick();
      got = sample(); want = sb.pop_front(); cmp_n++;
      if (got !== want) begin
        bad_n++; $display("FAIL seq[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    rows.delete();
  endtask

  task automatic test_jump_branch();
    obs_t got, want;
    rows.push_back(rw(JMP, 16'h0100, 16'h0, 1'b0, 1'b0, mk(16'h0100, 4'd0, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(BRR, 16'h0, 16'hFFFE, 1'b0, 1'b0, mk(16'h00FE, 4'd0, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(JMP, 16'h1234, 16'h0, 1'b0, 1'b1, mk(16'h00FE, 4'd0, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(BRR, 16'h0, 16'h0010, 1'b0, 1'b0, mk(16'h010E, 4'd0, 1'b0, 1'b0, 1'b0)));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i].exp);
      tick();
      got = sample(); want = sb.pop_front(); cmp_n++;
      if (got !== want) begin
        bad_n++; $display("FAIL jump_branch[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    rows.delete();
  endtask

  task automatic test_call_ret();
    obs_t got, want;
    rows.push_back(rw(JMP,  16'h0010, 16'h0, 1'b0, 1'b0, mk(16'h0010, 4'd0, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(CALL, 16'h0200, 16'h0, 1'b0, 1'b0, mk(16'h0200, 4'd1, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(CALL, 16'h0300, 16'h0, 1'b0, 1'b0, mk(16'h0300, 4'd2, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(CALL, 16'h0400, 16'h0, 1'b0, 1'b1, mk(16'h0300, 4'd2, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(RET,  16'h0000, 16'h0, 1'b0, 1'b0, mk(16'h0201, 4'd1, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(RET,  16'h0000, 16'h0, 1'b0, 1'b0, mk(16'h0011, 4'd0, 1'b0, 1'b0, 1'b0)));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i].exp);
      tick();
      got = sample(); want = sb.pop_front(); cmp_n++;
      if (got !== want) begin
        bad_n++; $display("FAIL call_ret[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    rows.delete();
  endtask

  task automatic test_overflow_underflow();
    obs_t got, want;
    apply_reset();
    for (int k = 1; k <= 9; k++) begin
      rows.push_back(rw(CALL, 16'h1000 + 16'(k), 16'h0, 1'b0, 1'b0,
                        mk(16'h1000 + 16'(k), (k > 8) ? 4'd8 : 4'(k), (k > 8), 1'b0, 1'b0)));
    end
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i].exp);
      tick();
      got = sample(); want = sb.pop_front(); cmp_n++;
      if (got !== want) begin
        bad_n++; $display("FAIL overflow[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    rows.delete();
    apply_reset();
    rows.push_back(rw(RET, 16'h0, 16'h0, 1'b0, 1'b0, mk(16'h0001, 4'd0, 1'b1, 1'b0, 1'b0)));
    rows.push_back(rw(SEQ, 16'h0, 16'h0, 1'b0, 1'b0, mk(16'h0002, 4'd0, 1'b1, 1'b0, 1'b0)));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i].exp);
      tick();
      got = sample(); want = sb.pop_front(); cmp_n++;
      if (got !== want) begin
        bad_n++; $display("FAIL underflow[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    rows.delete();
  endtask

  task automatic test_irq();
    obs_t got, want;
    apply_reset();
    rows.push_back(rw(JMP,  16'h0040, 16'h0, 1'b0, 1'b0, mk(16'h0040, 4'd0, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(JMP,  16'h0500, 16'h0, 1'b1, 1'b1, mk(16'h0040, 4'd0, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(JMP,  16'h0500, 16'h0, 1'b1, 1'b0, mk(16'h0004, 4'd1, 1'b0, 1'b1, 1'b1)));
    rows.push_back(rw(SEQ,  16'h0000, 16'h0, 1'b1, 1'b0, mk(16'h0005, 4'd1, 1'b0, 1'b1, 1'b0)));
    rows.push_back(rw(SEQ,  16'h0000, 16'h0, 1'b1, 1'b0, mk(16'h0006, 4'd1, 1'b0, 1'b1, 1'b0)));
    rows.push_back(rw(RETI, 16'h0000, 16'h0, 1'b0, 1'b0, mk(16'h0040, 4'd0, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(RETI, 16'h0000, 16'h0, 1'b0, 1'b0, mk(16'h0041, 4'd0, 1'b1, 1'b0, 1'b0)));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i].exp);
      tick();
      got = sample(); want = sb.pop_front(); cmp_n++;
      if (got !== want) begin
        bad_n++; $display("FAIL irq[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    rows.delete();
  endtask

  task automatic test_deferred_and_async_reset();
    obs_t got, want;
    apply_reset();
    // Eight calls from pc 0: return addresses 0x0001, then 0x2002..0x2008.
    for (int k = 1; k <= 8; k++) begin
      rows.push_back(rw(CALL, 16'h2000 + 16'(k), 16'h0, 1'b0, 1'b0,
                        mk(16'h2000 + 16'(k), 4'(k), 1'b0, 1'b0, 1'b0)));
    end
    rows.push_back(rw(SEQ, 16'h0, 16'h0, 1'b1, 1'b0, mk(16'h2009, 4'd8, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(RET, 16'h0, 16'h0, 1'b1, 1'b0, mk(16'h2008, 4'd7, 1'b0, 1'b0, 1'b0)));
    rows.push_back(rw(SEQ, 16'h0, 16'h0, 1'b1, 1'b0, mk(16'h0004, 4'd8, 1'b0, 1'b1, 1'b1)));
    rows.push_back(rw(SEQ, 16'h0, 16'h0, 1'b0, 1'b0, mk(16'h0005, 4'd8, 1'b0, 1'b1, 1'b0)));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i].exp);
      tick();
      got = sample(); want = sb.pop_front(); cmp_n++;
      if (got !== want) begin
        bad_n++; $display("FAIL deferred[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    rows.delete();
    // Assert reset between edges; the state must clear without a clock edge.
    rst = 1'b1;
    sb.push_back(mk(16'h0000, 4'd0, 1'b0, 1'b0, 1'b0));
    #2;
    got = sample(); want = sb.pop_front(); cmp_n++;
    if (got !== want) begin
      bad_n++; $display("FAIL async_reset: got %s want %s", fmt(got), fmt(want));
    end
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seq();
    test_jump_branch();
    test_call_ret();
    test_overflow_underflow();
    test_irq();
    test_deferred_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule
